// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - NUM_LEDS animation generator (bounce/rotate/fill/blink) with programmable prescaler; LED_CYCLE_CNT_EN adds cycle_count
module led_pattern_gen #(
    parameter int NUM_LEDS = 10,
    parameter int DIV_W    = 32,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [DIV_W-1:0]    period,
    output logic [NUM_LEDS-1:0] leds,
    output logic                dir,
    output logic                step_pulse,
    output logic                cycle_done
`ifdef LED_CYCLE_CNT_EN
    ,
    output logic [CNT_W-1:0]    cycle_count
`endif
);

    typedef enum logic [1:0] {
        M_BOUNCE = 2'd0,
        M_ROTATE = 2'd1,
        M_FILL   = 2'd2,
        M_BLINK  = 2'd3
    } mode_e;

    localparam logic [NUM_LEDS-1:0] ONE = {{(NUM_LEDS-1){1'b0}}, 1'b1};

    if (NUM_LEDS < 2 || CNT_W < 1) begin : g_bad_param
        $error("led_pattern_gen: NUM_LEDS must be >= 2 and CNT_W >= 1");
    end

    mode_e               mode_q;
    logic [DIV_W-1:0]    cnt;
    logic                mode_chg;
    logic                step;
    logic [NUM_LEDS-1:0] shl;
    logic [NUM_LEDS-1:0] shr;
    logic [NUM_LEDS-1:0] nxt_leds;
    logic                nxt_dir;
    logic                nxt_done;
    logic [NUM_LEDS-1:0] start_leds;

    assign mode_chg   = (mode != mode_q);
    assign step       = !mode_chg && en && (cnt >= period);
    assign start_leds = (mode == M_BOUNCE || mode == M_ROTATE) ? ONE : '0;
    assign shl        = leds << 1;
    assign shr        = leds >> 1;

    // Next pattern for one step in the current mode; only applied when step is high.
    always_comb begin
        nxt_leds = leds;
        nxt_dir  = dir;
        nxt_done = 1'b0;
        unique case (mode_q)
            M_BOUNCE: begin
                if (leds == '0) begin
                    nxt_leds = ONE;
                    nxt_dir  = 1'b0;
                end else if (!dir) begin
                    nxt_leds = shl;
                    nxt_dir  = shl[NUM_LEDS-1];
                end else begin
                    nxt_leds = shr;
                    if (shr == ONE) begin
                        nxt_dir  = 1'b0;
                        nxt_done = 1'b1;
                    end
                end
            end
            M_ROTATE: begin
                nxt_dir = 1'b0;
                if (leds == '0) begin
                    nxt_leds = ONE;
                end else begin
                    nxt_leds = {leds[NUM_LEDS-2:0], leds[NUM_LEDS-1]};
                    nxt_done = ({leds[NUM_LEDS-2:0], leds[NUM_LEDS-1]} == ONE);
                end
            end
            M_FILL: begin
                if (&leds) begin
                    nxt_leds = '0;
                    nxt_done = 1'b1;
                end else begin
                    nxt_leds = shl | ONE;
                end
            end
            M_BLINK: begin
                nxt_leds = ~leds;
                nxt_done = (~leds == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            leds       <= ONE;
            dir        <= 1'b0;
            cnt        <= '0;
            mode_q     <= M_BOUNCE;
            step_pulse <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            step_pulse <= step;
            cycle_done <= step && nxt_done;
            if (mode_chg) begin
                mode_q <= mode_e'(mode);
                cnt    <= '0;
                dir    <= 1'b0;
                leds   <= start_leds;
            end else if (en) begin
                if (step) begin
                    cnt  <= '0;
                    leds <= nxt_leds;
                    dir  <= nxt_dir;
                end else begin
                    cnt  <= cnt + DIV_W'(1);
                end
            end
        end
    end

`ifdef LED_CYCLE_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n || mode_chg) begin
            cycle_count <= '0;
        end else if (step && nxt_done) begin
            cycle_count <= cycle_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - scoreboard bench for led_pattern_gen
module tb_led_pattern_gen;

    localparam int N  = 10;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [DW-1:0] period = '0;
    logic [N-1:0]  leds;
    logic          dir;
    logic          step_pulse;
    logic          cycle_done;
    logic [CW-1:0] cc_obs;
`ifdef LED_CYCLE_CNT_EN
    logic [CW-1:0] cycle_count;
    assign cc_obs = cycle_count;
`else
    assign cc_obs = '0;
`endif

    always #5 clk = ~clk;

    led_pattern_gen #(.NUM_LEDS(N), .DIV_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .period     (period),
        .leds       (leds),
        .dir        (dir),
        .step_pulse (step_pulse),
`ifdef LED_CYCLE_CNT_EN
        .cycle_count(cycle_count),
`endif
        .cycle_done (cycle_done)
    );

    typedef struct packed {
        logic [N-1:0]  leds;
        logic          dir;
        logic          sp;
        logic          cd;
        logic [CW-1:0] cc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0] m_cnt;
    logic [N-1:0]  m_leds;
    logic          m_dir;
    logic [1:0]    m_mode;
    logic [CW-1:0] m_cc;
    logic [N-1:0]  one_n = 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour of one rising edge given the inputs currently driven.
    task automatic model_edge();
        exp_t e;
        e = '0;
        if (!rst_n) begin
            m_cnt = '0; m_leds = one_n; m_dir = 1'b0; m_mode = 2'd0; m_cc = '0;
        end else if (mode != m_mode) begin
            m_mode = mode; m_cnt = '0; m_dir = 1'b0; m_cc = '0;
            m_leds = (mode <= 2'd1) ? one_n : '0;
        end else if (en) begin
            if (m_cnt >= period) begin
                m_cnt = '0;
                e.sp  = 1'b1;
                case (m_mode)
                    2'd0: begin
                        if (m_leds == '0) begin
                            m_leds = one_n; m_dir = 1'b0;
                        end else if (!m_dir) begin
                            m_leds = m_leds << 1;
                            if (m_leds[N-1]) m_dir = 1'b1;
                        end else begin
                            m_leds = m_leds >> 1;
                            if (m_leds == one_n) begin m_dir = 1'b0; e.cd = 1'b1; end
                        end
                    end
                    2'd1: begin
                        if (m_leds == '0) m_leds = one_n;
                        else begin
                            m_leds = {m_leds[N-2:0], m_leds[N-1]};
                            e.cd = (m_leds == one_n);
                        end
                    end
                    2'd2: begin
                        if (&m_leds) begin m_leds = '0; e.cd = 1'b1; end
                        else m_leds = (m_leds << 1) | one_n;
                    end
                    default: begin
                        m_leds = ~m_leds;
                        e.cd = (m_leds == '0);
                    end
                endcase
                if (e.cd) m_cc = m_cc + 1'b1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        e.leds = m_leds; e.dir = m_dir; e.cc = m_cc;
        sb.push_back(e);
    endtask

    task automatic tick(input logic r, input logic e_in, input logic [1:0] m, input logic [DW-1:0] p);
        exp_t x;
        rst_n = r; en = e_in; mode = m; period = p;
        model_edge();
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check_val("leds", 64'(leds), 64'(x.leds));
        check_val("dir", 64'(dir), 64'(x.dir));
        check_val("step_pulse", 64'(step_pulse), 64'(x.sp));
        check_val("cycle_done", 64'(cycle_done), 64'(x.cd));
`ifdef LED_CYCLE_CNT_EN
        check_val("cycle_count", 64'(cc_obs), 64'(x.cc));
`endif
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] ev;
        int           blink_done;
        @(negedge clk);

        // Reset then bounce, period 3
        tick(1'b0, 1'b1, 2'd0, 3);
        tick(1'b0, 1'b1, 2'd0, 3);
        check_val("rst_leds", 64'(leds), 64'd1);
        check_val("rst_sp", 64'(step_pulse), 64'd0);
        for (int s = 1; s <= 18; s++) begin
            for (int k = 0; k < 4; k++) tick(1'b1, 1'b1, 2'd0, 3);
            ev = (s <= 9) ? (one_n << s) : (one_n << (18 - s));
            check_val("bounce_leds", 64'(leds), 64'(ev));
            check_val("bounce_sp", 64'(step_pulse), 64'd1);
            if (s == 9)  check_val("bounce_dir9", 64'(dir), 64'd1);
            if (s == 18) check_val("bounce_done", 64'(cycle_done), 64'd1);
        end

        // Rotate, period 0
        tick(1'b1, 1'b1, 2'd1, 0);
        check_val("rot_start", 64'(leds), 64'd1);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b1, 2'd1, 0);
            ev = (i == 9) ? one_n : (one_n << (i + 1));
            check_val("rot_leds", 64'(leds), 64'(ev));
            check_val("rot_done", 64'(cycle_done), 64'(i == 9));
        end

        // Fill, period 0
        tick(1'b1, 1'b1, 2'd2, 0);
        check_val("fill_start", 64'(leds), 64'd0);
        for (int i = 0; i < 11; i++) begin
            tick(1'b1, 1'b1, 2'd2, 0);
            ev = (i == 10) ? '0 : ((one_n << (i + 1)) - one_n);
            check_val("fill_leds", 64'(leds), 64'(ev));
            check_val("fill_done", 64'(cycle_done), 64'(i == 10));
        end

        // en gating, then period lowered below cnt
        tick(1'b1, 1'b1, 2'd0, 3);
        tick(1'b1, 1'b1, 2'd0, 3);
        tick(1'b1, 1'b1, 2'd0, 3);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, 2'd0, 3);
            check_val("hold_leds", 64'(leds), 64'd1);
            check_val("hold_sp", 64'(step_pulse), 64'd0);
        end
        tick(1'b1, 1'b0, 2'd0, 0);
        tick(1'b1, 1'b1, 2'd0, 0);
        check_val("lowered_sp", 64'(step_pulse), 64'd1);
        check_val("lowered_leds", 64'(leds), 64'd2);

        // Mode change mid-bounce at leds=64, dir=1
        for (int i = 0; i < 11; i++) tick(1'b1, 1'b1, 2'd0, 0);
        check_val("mid_leds", 64'(leds), 64'd64);
        check_val("mid_dir", 64'(dir), 64'd1);
        tick(1'b1, 1'b1, 2'd3, 0);
        check_val("mc_leds", 64'(leds), 64'd0);
        check_val("mc_dir", 64'(dir), 64'd0);
        check_val("mc_sp", 64'(step_pulse), 64'd0);
        tick(1'b1, 1'b1, 2'd3, 0);
        check_val("blink_leds", 64'(leds), 64'd1023);
        check_val("blink_sp", 64'(step_pulse), 64'd1);

        // Sync reset on the cycle a step would fire
        tick(1'b1, 1'b1, 2'd1, 1);
        tick(1'b1, 1'b1, 2'd1, 1);
        tick(1'b0, 1'b1, 2'd1, 1);
        check_val("srst_leds", 64'(leds), 64'd1);
        check_val("srst_dir", 64'(dir), 64'd0);
        check_val("srst_sp", 64'(step_pulse), 64'd0);
        check_val("srst_cc", 64'(cc_obs), 64'd0);

        // Blink, period 2
        blink_done = 0;
        tick(1'b1, 1'b1, 2'd3, 2);
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b1, 2'd3, 2);
            if (cycle_done) blink_done++;
        end
        check_val("blink_done_cnt", 64'(blink_done), 64'd2);
        check_val("blink_final", 64'(leds), 64'd0);

        check_val("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
